booth_mul_seq: RTL and testbench

Parametrised sequential signed multiplier for the multiplier datapath. Computes a two's-complement WIDTH×WIDTH → 2·WIDTH product with radix-4 Booth recoding, one recoded digit per clock. All add/subtract work goes through a parametrised carry-lookahead add/sub unit. Sits between operand registers and the result bus, with a start/done/clear handshake.

---
 rtl/booth_pkg.sv | 28 ++
 rtl/cla_addsub.sv | 54 +++++
 rtl/booth_mul_seq.sv | 123 ++++++++++++
 tb/tb_booth_mul_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
//   state_e : controller states (fixed encoding)
//   digit_e : recoded Booth digit selecting 0, +M, +2M, -M or -2M
//   cnt_width() : step counter width for a given operand width
package booth_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StDone = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    DigZero,
    DigPm,
    DigP2m,
    DigMm,
    DigM2m
  } digit_e;

  // ceil(log2(width/2)), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = $clog2(width / 2);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cla_addsub.sv
// Combinational N-bit adder built from 4-bit carry-lookahead groups with the
// group carries rippling. Subtraction is done by the caller as a + ~b, ci=1.
//   a, b : addends (N bits)
//   ci   : carry in
//   s    : sum (N bits)
//   co   : carry out of bit N-1
module cla_addsub #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  localparam int unsigned NG = (N + 3) / 4;
  localparam int unsigned NP = NG * 4;

  logic [NP-1:0] ap, bp, sp;
  logic [NG:0]   c;

  // Zero padding: padded bits have p=g=0, so the first padded sum bit is the
  // carry out of bit N-1.
  assign ap   = NP'(a);
  assign bp   = NP'(b);
  assign c[0] = ci;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    logic [3:0] p, g;
    logic       c1, c2, c3, c4, cin;
    assign p   = ap[4*gi +: 4] ^ bp[4*gi +: 4];
    assign g   = ap[4*gi +: 4] & bp[4*gi +: 4];
    assign cin = c[gi];
    assign c1  = g[0] | (p[0] & cin);
    assign c2  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c4  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sp[4*gi +: 4] = p ^ {c3, c2, c1, cin};
    assign c[gi+1]       = c4;
  end

  assign s = sp[N-1:0];

  if (NP > N) begin : g_pad
    logic [NP-N:0] unused_pad;
    assign co         = sp[N];
    assign unused_pad = {c[NG], sp[NP-1:N]};
  end else begin : g_nopad
    assign co = c[NG];
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed WIDTH x WIDTH -> 2*WIDTH multiplier, radix-4 Booth, one
// recoded digit per clock.
//   clk, reset   : clock, asynchronous active-high reset
//   op_start     : start request, sampled in idle only
//   op_clear     : synchronous abort/acknowledge, highest priority
//   multiplicand : signed operand M, captured on the start edge
//   multiplier   : signed operand Q, captured on the start edge
//   result       : signed product, valid while op_done
//   op_done      : product valid (registered)
//   busy         : operation in progress (registered)
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   result,
  output logic                 op_done,
  output logic                 busy
);

  localparam int unsigned AW   = WIDTH + 2;
  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH / 2 - 1);

  state_e          state_q;
  logic [AW-1:0]   acc_q, m_q;
  logic [WIDTH-1:0] q_q;
  logic            qm1_q;
  logic [CntW-1:0] cnt_q;

  digit_e          digit;
  logic [AW-1:0]   mag, add_b, sum, acc_new, acc_next;
  logic [WIDTH-1:0] q_next;
  logic            sub, unused_co;

  always_comb begin
    digit = DigZero;
    unique case ({q_q[1:0], qm1_q})
      3'b000, 3'b111: digit = DigZero;
      3'b001, 3'b010: digit = DigPm;
      3'b011:         digit = DigP2m;
      3'b100:         digit = DigM2m;
      3'b101, 3'b110: digit = DigMm;
      default:        digit = DigZero;
    endcase

    mag = m_q;
    sub = 1'b0;
    if (digit == DigP2m || digit == DigM2m) mag = {m_q[AW-2:0], 1'b0};
    if (digit == DigMm || digit == DigM2m) sub = 1'b1;
    add_b = sub ? ~mag : mag;
  end

  cla_addsub #(
    .N(AW)
  ) u_addsub (
    .a (acc_q),
    .b (add_b),
    .ci(sub),
    .s (sum),
    .co(unused_co)
  );

  // Arithmetic shift of {A', Q, q_m1} right by two.
  always_comb begin
    acc_new  = (digit == DigZero) ? acc_q : sum;
    acc_next = {{2{acc_new[AW-1]}}, acc_new[AW-1:2]};
    q_next   = {acc_new[1:0], q_q[WIDTH-1:2]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      result  <= '0;
      op_done <= 1'b0;
      busy    <= 1'b0;
    end else if (op_clear) begin
      state_q <= StIdle;
      op_done <= 1'b0;
      busy    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (op_start) begin
            acc_q   <= '0;
            q_q     <= multiplier;
            qm1_q   <= 1'b0;
            m_q     <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StExec;
          end
        end
        StExec: begin
          acc_q <= acc_next;
          q_q   <= q_next;
          qm1_q <= q_q[1];
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            result  <= {acc_next[WIDTH-1:0], q_next};
            op_done <= 1'b1;
            busy    <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: ;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
module tb_booth_mul_seq;

  logic clk, reset;

  logic         start64, clear64, done64, busy64;
  logic [63:0]  mc64, mp64;
  logic [127:0] res64;

  logic         start8, clear8, done8, busy8;
  logic [7:0]   mc8, mp8;
  logic [15:0]  res8;

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] last_exp64, last_exp8;

  booth_mul_seq #(.WIDTH(64)) dut64 (
    .clk         (clk),
    .reset       (reset),
    .op_start    (start64),
    .op_clear    (clear64),
    .multiplicand(mc64),
    .multiplier  (mp64),
    .result      (res64),
    .op_done     (done64),
    .busy        (busy64)
  );

  booth_mul_seq #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .reset       (reset),
    .op_start    (start8),
    .op_clear    (clear8),
    .multiplicand(mc8),
    .multiplier  (mp8),
    .result      (res8),
    .op_done     (done8),
    .busy        (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // One full operation on either instance, with inputs scrambled during EXEC.
  task automatic run_op(input bit w8, input logic [63:0] m, input logic [63:0] q);
    logic signed [127:0] ms, qs, exp, got;
    logic signed [7:0]   m8, q8;
    logic signed [15:0]  p8;
    int half, lat, nbusy;
    half = w8 ? 4 : 32;
    if (w8) begin
      m8  = m[7:0];
      q8  = q[7:0];
      p8  = m8 * q8;
      exp = p8;
    end else begin
      ms  = $signed(m);
      qs  = $signed(q);
      exp = ms * qs;
    end
    @(negedge clk);
    if (w8) begin
      mc8 = m[7:0]; mp8 = q[7:0]; start8 = 1'b1;
    end else begin
      mc64 = m; mp64 = q; start64 = 1'b1;
    end
    @(negedge clk);
    start8  = 1'b0;
    start64 = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (!(w8 ? done8 : done64) && lat < half + 4) begin
      if (w8 ? busy8 : busy64) nbusy++;
      mc64 = rand64(); mp64 = rand64();
      mc8  = 8'($urandom); mp8 = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    got = w8 ? {{112{res8[15]}}, res8} : res64;
    check_eq(w8 ? "latency8" : "latency64", 128'(lat), 128'(half));
    check_eq(w8 ? "busy_cycles8" : "busy_cycles64", 128'(nbusy), 128'(half));
    check_eq(w8 ? "busy_at_done8" : "busy_at_done64", {127'd0, w8 ? busy8 : busy64}, 128'd0);
    check_eq(w8 ? "product8" : "product64", got, exp);
    @(negedge clk);
    if (w8) clear8 = 1'b1; else clear64 = 1'b1;
    @(negedge clk);
    clear8  = 1'b0;
    clear64 = 1'b0;
    got = w8 ? {{112{res8[15]}}, res8} : res64;
    check_eq(w8 ? "done_clr8" : "done_clr64", {127'd0, w8 ? done8 : done64}, 128'd0);
    check_eq(w8 ? "hold8" : "hold64", got, exp);
    if (w8) last_exp8 = exp; else last_exp64 = exp;
  endtask

  initial begin
    int vals8[6] = '{-128, -1, 0, 1, 127, -127};
    bit rose;
    reset = 1'b1;
    start64 = 0; clear64 = 0; mc64 = '0; mp64 = '0;
    start8  = 0; clear8  = 0; mc8  = '0; mp8  = '0;
    last_exp64 = '0;
    last_exp8  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_res64", res64, 128'd0);
    check_eq("rst_done64", {127'd0, done64}, 128'd0);
    check_eq("rst_busy64", {127'd0, busy64}, 128'd0);
    check_eq("rst_res8", {112'd0, res8}, 128'd0);
    check_eq("rst_done8", {127'd0, done8}, 128'd0);
    check_eq("rst_busy8", {127'd0, busy8}, 128'd0);
    reset = 1'b0;

    // Directed WIDTH=64 cases.
    run_op(1'b0, 64'd7, 64'd5);
    run_op(1'b0, -64'sd7, 64'd5);
    run_op(1'b0, 64'd814, -64'sd1220);
    run_op(1'b0, 64'd110080, 64'd20070);
    run_op(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    run_op(1'b0, 64'h8000_0000_0000_0000, {64{1'b1}});
    run_op(1'b0, 64'd0, {64{1'b1}});
    run_op(1'b0, 64'h7fff_ffff_ffff_ffff, 64'h8000_0000_0000_0000);
    for (int i = 0; i < 20; i++) run_op(1'b0, rand64(), rand64());

    // Abort mid-EXEC: back to idle, no done, result untouched.
    @(negedge clk);
    mc64 = rand64(); mp64 = rand64(); start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    repeat (10) @(negedge clk);
    clear64 = 1'b1;
    @(negedge clk);
    clear64 = 1'b0;
    check_eq("abort_busy64", {127'd0, busy64}, 128'd0);
    rose = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done64 || busy64) rose = 1'b1;
    end
    check_eq("abort_quiet64", {127'd0, rose}, 128'd0);
    check_eq("abort_hold64", res64, last_exp64);

    // WIDTH=8: corner pairs, then a random sample of the operand space.
    foreach (vals8[i]) foreach (vals8[j]) run_op(1'b1, 64'(vals8[i]), 64'(vals8[j]));
    for (int i = 0; i < 1200; i++) run_op(1'b1, 64'($urandom), 64'($urandom));

    // Start together with clear in idle: nothing happens.
    @(negedge clk);
    mc8 = 8'd3; mp8 = 8'd9; start8 = 1'b1; clear8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; clear8 = 1'b0;
    check_eq("startclr_busy8", {127'd0, busy8}, 128'd0);
    repeat (6) @(negedge clk);
    check_eq("startclr_done8", {127'd0, done8}, 128'd0);
    check_eq("startclr_hold8", {{112{res8[15]}}, res8}, last_exp8);

    // Asynchronous reset mid-EXEC.
    run_op(1'b0, 64'd123456789, -64'sd987654321);
    @(negedge clk);
    mc64 = 64'd99; mp64 = 64'd77; start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_res64", res64, 128'd0);
    check_eq("arst_done64", {127'd0, done64}, 128'd0);
    check_eq("arst_busy64", {127'd0, busy64}, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b0, 64'd7, 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
